// File: rtl/addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// addsub_pipe_if
//   Handshake/data bundle for the pipelined add/subtract unit.
//
//   Parameter:
//     WIDTH      operand/result width in bits
//
//   Signals (directions seen from the unit, i.e. the slave modport):
//     in_valid   in   operands valid
//     in_ready   out  unit can accept this cycle
//     in_a       in   operand a
//     in_b       in   operand b
//     in_sub     in   1: a-b, 0: a+b
//     in_sat     in   saturate on signed overflow (only with ADDSUB_SAT_EN)
//     out_valid  out  result valid
//     out_ready  in   consumer accepts result
//     out_sum    out  result mod 2^WIDTH (or saturated value)
//     out_cout   out  carry out; for subtract 1 = no borrow
//     out_ovf    out  signed overflow
//
//   Build option: define ADDSUB_SAT_EN to add the in_sat signal.
// ----------------------------------------------------------------------------
interface addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
`ifdef ADDSUB_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_sub,
`ifdef ADDSUB_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_sub,
`ifdef ADDSUB_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// ----------------------------------------------------------------------------
// addsub_pipe
//   Pipelined two's-complement add/subtract over a Kogge-Stone parallel-prefix
//   carry network. A pipeline register follows every LPS prefix levels (only
//   where levels remain below it), plus one output register, so the latency
//   is ceil(clog2(WIDTH)/LPS) cycles at one operation per cycle.
//
//   Parameters:
//     WIDTH  operand/result width (>= 2)
//     LPS    prefix levels per pipeline stage (>= 1)
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-high reset (drops all in-flight ops, zeroes
//            the output register)
//     clr    synchronous flush of all in-flight ops (wins over an accept)
//     bus    addsub_pipe_if.slave: in_valid/in_ready/in_a/in_b/in_sub
//            [/in_sat], out_valid/out_ready/out_sum/out_cout/out_ovf
//
//   Build option: ADDSUB_SAT_EN adds in_sat; when set on an op that
//   overflows, out_sum saturates toward the sign of operand a.
// ----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LPS   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    addsub_pipe_if.slave bus
);
    // Prefix depth, padded tree width, stage count, inter-stage register count.
    localparam int unsigned L   = $clog2(WIDTH);
    localparam int unsigned N   = 1 << L;
    localparam int unsigned LAT = (L + LPS - 1) / LPS;
    localparam int unsigned QN  = (LAT > 1) ? LAT - 1 : 1;

    // Everything an op needs further down the pipe.
    typedef struct packed {
        logic             valid;
        logic [N-1:0]     g;      // group generate, carry-in folded at bit 0
        logic [N-1:0]     p;      // group propagate
        logic [WIDTH-1:0] p0;     // bitwise propagate for the final sum
        logic             cin;
        logic             a_msb;
        logic             b_msb;  // msb of b after the subtract inversion
`ifdef ADDSUB_SAT_EN
        logic             sat;
`endif
    } stage_t;

    stage_t           st0;
    stage_t           r_arr [LAT];  // each stage's state after its prefix levels
    stage_t           q     [QN];   // inter-stage registers
    logic [WIDTH-1:0] b_x;
    logic             stall;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;

    // Every stage moves together; only a held result blocks the pipe.
    assign stall         = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

    // Level 0: a - b is a + ~b + 1. The carry-in is folded into G[0] so the
    // prefix tree yields every carry directly; padded bits stay P=0, G=0.
    always_comb begin
        b_x                = bus.in_b ^ {WIDTH{bus.in_sub}};
        st0                = '0;
        st0.valid          = bus.in_valid;
        st0.p0             = bus.in_a ^ b_x;
        st0.p[WIDTH-1:0]   = st0.p0;
        st0.g[WIDTH-1:0]   = bus.in_a & b_x;
        st0.g[0]           = st0.g[0] | (st0.p0[0] & bus.in_sub);
        st0.cin            = bus.in_sub;
        st0.a_msb          = bus.in_a[WIDTH-1];
        st0.b_msb          = b_x[WIDTH-1];
`ifdef ADDSUB_SAT_EN
        st0.sat            = bus.in_sat;
`endif
    end

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int unsigned LO = s * LPS + 1;
        localparam int unsigned HI = ((s + 1) * LPS < L) ? (s + 1) * LPS : L;

        stage_t d;

        if (s == 0) begin : g_src
            assign d = st0;
        end else begin : g_src
            assign d = q[s-1];
        end

        // Kogge-Stone levels LO..HI. Walking i downward lets each level update
        // in place: lower indices still hold the previous level's values.
        always_comb begin
            stage_t w;
            w = d;
            for (int unsigned lvl = LO; lvl <= HI; lvl++) begin
                for (int unsigned i = N - 1; i >= (1 << (lvl - 1)); i--) begin
                    w.g[i] = w.g[i] | (w.p[i] & w.g[i - (1 << (lvl - 1))]);
                    w.p[i] = w.p[i] & w.p[i - (1 << (lvl - 1))];
                end
            end
            r_arr[s] = w;
        end

        if (s < LAT - 1) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q[s] <= '0;
                end else begin
                    if (!stall) begin
                        q[s] <= r_arr[s];
                    end
                    if (clr) begin
                        q[s].valid <= 1'b0;
                    end
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] carry;
            logic [WIDTH-1:0] sum_w;
            logic [WIDTH-1:0] sum_f;
            logic             cout_f;
            logic             ovf_f;

            // After the full tree, G[i] is the carry into bit i+1.
            always_comb begin
                carry  = {r_arr[s].g[WIDTH-2:0], r_arr[s].cin};
                sum_w  = r_arr[s].p0 ^ carry;
                cout_f = r_arr[s].g[WIDTH-1];
                ovf_f  = (r_arr[s].a_msb == r_arr[s].b_msb) &&
                         (sum_w[WIDTH-1] != r_arr[s].a_msb);
                sum_f  = sum_w;
`ifdef ADDSUB_SAT_EN
                if (r_arr[s].sat && ovf_f) begin
                    sum_f = r_arr[s].a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_cout_q  <= 1'b0;
                    out_ovf_q   <= 1'b0;
                end else begin
                    if (!stall) begin
                        out_valid_q <= r_arr[s].valid;
                        out_sum_q   <= sum_f;
                        out_cout_q  <= cout_f;
                        out_ovf_q   <= ovf_f;
                    end
                    if (clr) begin
                        out_valid_q <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst;
    logic clr32;
    logic clr8;

    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(32)) if32 ();
    addsub_pipe_if #(.WIDTH(8))  if8 ();

    addsub_pipe #(.WIDTH(32), .LPS(2)) dut32 (
        .clk (clk),
        .rst (rst),
        .clr (clr32),
        .bus (if32)
    );

    addsub_pipe #(.WIDTH(8), .LPS(1)) dut8 (
        .clk (clk),
        .rst (rst),
        .clr (clr8),
        .bus (if8)
    );

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        logic [31:0] sum;
        bit          cout;
        bit          ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t q32[$];
    res_t q8[$];
    res_t exp32;
    res_t exp8;
    vec_t vt [11];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: unsigned carry and signed range from plain integer arithmetic.
    function automatic res_t model(input int unsigned w, input longint unsigned a,
                                   input longint unsigned b, input bit sub, input bit sat);
        res_t            r;
        longint unsigned m;
        longint          sa, sb, sr, smax, smin;
        m     = (64'd1 << w) - 64'd1;
        smax  = (longint'(1) <<< (w - 1)) - 1;
        smin  = -smax - 1;
        sa    = a[w-1] ? longint'(a) - longint'(m) - 1 : longint'(a);
        sb    = b[w-1] ? longint'(b) - longint'(m) - 1 : longint'(b);
        sr    = sub ? sa - sb : sa + sb;
        r.ovf = (sr > smax) || (sr < smin);
        r.sum = (sub ? (a - b) : (a + b)) & m;
        r.cout = sub ? (a >= b) : (((a + b) >> w) != 0);
        if (sat && r.ovf)
            r.sum = (sa >= 0) ? longint'(smax) : longint'(smax) + 1;
        return r;
    endfunction

    // Scoreboards: sample on the falling edge, i.e. what the next rising edge transfers.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q32.delete();
        end else begin
            if (if32.out_valid && if32.out_ready) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected32: got 0x%0h expected no result", if32.out_sum);
                end else begin
                    e = q32.pop_front();
                    chk("sum32", 64'(if32.out_sum), e.sum);
                    chk("cout32", 64'(if32.out_cout), 64'(e.cout));
                    chk("ovf32", 64'(if32.out_ovf), 64'(e.ovf));
                end
            end
            if (clr32)
                q32.delete();
            else if (if32.in_valid && if32.in_ready)
                q32.push_back(exp32);
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q8.delete();
        end else begin
            if (if8.out_valid && if8.out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected8: got 0x%0h expected no result", if8.out_sum);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", 64'(if8.out_sum), e.sum);
                    chk("cout8", 64'(if8.out_cout), 64'(e.cout));
                    chk("ovf8", 64'(if8.out_ovf), 64'(e.ovf));
                end
            end
            if (clr8)
                q8.delete();
            else if (if8.in_valid && if8.in_ready)
                q8.push_back(exp8);
        end
    end

    task automatic idle32();
        if32.in_valid  = 1'b0;
        if32.in_a      = '0;
        if32.in_b      = '0;
        if32.in_sub    = 1'b0;
        if32.out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        if32.in_sat    = 1'b0;
`endif
    endtask

    task automatic idle8();
        if8.in_valid  = 1'b0;
        if8.in_a      = '0;
        if8.in_b      = '0;
        if8.in_sub    = 1'b0;
        if8.out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        if8.in_sat    = 1'b0;
`endif
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input bit sub, input res_t e);
        if32.in_valid = 1'b1;
        if32.in_a     = a;
        if32.in_b     = b;
        if32.in_sub   = sub;
        exp32         = e;
    endtask

    task automatic drain32(input string tag);
        for (int c = 0; c < 20 && q32.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(q32.size()), 64'd0);
    endtask

    task automatic drain8(input string tag);
        for (int c = 0; c < 20 && q8.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(q8.size()), 64'd0);
    endtask

    // Called at posedge+1: accept at edge k, result visible only after edge k+2.
    task automatic latency32(input string tag);
        drive32(32'd5, 32'd7, 1'b1, '{64'hFFFF_FFFE, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        idle32();
        chk({tag, "_v_k"}, 64'(if32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_v_k1"}, 64'(if32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_v_k2"}, 64'(if32.out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_v_k3"}, 64'(if32.out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          sub;
        bit          sat;
        int          acc8;
        int          cyc;

        vt = '{
            '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
            '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
            '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
            '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0},
            '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0},
            '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h5555_5555, 1'b1, 1'b1}
        };

        rst   = 1'b0;
        clr32 = 1'b0;
        clr8  = 1'b0;
        idle32();
        idle8();
        exp32 = '{64'd0, 1'b0, 1'b0};
        exp8  = '{64'd0, 1'b0, 1'b0};

        // Reset state.
        #1 rst = 1'b1;
        #2;
        chk("rst_valid32", 64'(if32.out_valid), 64'd0);
        chk("rst_sum32", 64'(if32.out_sum), 64'd0);
        chk("rst_cout32", 64'(if32.out_cout), 64'd0);
        chk("rst_ovf32", 64'(if32.out_ovf), 64'd0);
        chk("rst_valid8", 64'(if8.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy32_after_rst", 64'(if32.in_ready), 64'd1);
        chk("rdy8_after_rst", 64'(if8.in_ready), 64'd1);

        // First-result latency on both configurations.
        latency32("lat32");
        if8.in_valid = 1'b1;
        if8.in_a     = 8'h7F;
        if8.in_b     = 8'h01;
        exp8         = '{64'h80, 1'b0, 1'b1};
        @(posedge clk);
        #1;
        idle8();
        chk("lat8_v_k", 64'(if8.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat8_v_k1", 64'(if8.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat8_v_k2", 64'(if8.out_valid), 64'd1);
        drain8("drain8_lat");

        // Table vectors, back to back.
        foreach (vt[i]) begin
            drive32(vt[i].a, vt[i].b, vt[i].sub, '{64'(vt[i].sum), vt[i].cout, vt[i].ovf});
            @(posedge clk);
            #1;
        end
        idle32();
        drain32("drain32_table");

`ifdef ADDSUB_SAT_EN
        drive32(32'h8000_0000, 32'h1, 1'b1, '{64'h8000_0000, 1'b1, 1'b1});
        if32.in_sat = 1'b1;
        @(posedge clk);
        #1;
        drive32(32'h8000_0000, 32'h1, 1'b1, '{64'h7FFF_FFFF, 1'b1, 1'b1});
        if32.in_sat = 1'b0;
        @(posedge clk);
        #1;
        idle32();
        drain32("drain32_sat");
`endif

        // Eight back-to-back ops; consumer stalls 3 cycles at the 2nd result.
        fork
            begin : producer
                bit acc;
                int guard;
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] pa, pb;
                    bit          ps;
                    pa = $urandom;
                    pb = $urandom;
                    ps = 1'($urandom_range(0, 1));
                    drive32(pa, pb, ps, model(32, 64'(pa), 64'(pb), ps, 1'b0));
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = if32.in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!acc && guard < 20);
                    if (!acc)
                        chk("stall_accept_timeout", 64'd0, 64'd1);
                end
                if32.in_valid = 1'b0;
            end
            begin : consumer
                int          seen;
                logic [31:0] hs;
                logic        hc, ho;
                seen = 0;
                for (int c = 0; c < 40 && seen < 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (if32.out_valid)
                        seen++;
                end
                chk("stall_reach_2nd", 64'(seen), 64'd2);
                chk("stall_rdy_before", 64'(if32.in_ready), 64'd1);
                if32.out_ready = 1'b0;
                hs = if32.out_sum;
                hc = if32.out_cout;
                ho = if32.out_ovf;
                #1;
                chk("stall_rdy_0", 64'(if32.in_ready), 64'd0);
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid_held", 64'(if32.out_valid), 64'd1);
                    chk("stall_sum_held", 64'(if32.out_sum), 64'(hs));
                    chk("stall_cout_held", 64'(if32.out_cout), 64'(hc));
                    chk("stall_ovf_held", 64'(if32.out_ovf), 64'(ho));
                    if (c < 2)
                        chk("stall_rdy_low", 64'(if32.in_ready), 64'd0);
                end
                if32.out_ready = 1'b1;
                #1;
                chk("stall_rdy_release", 64'(if32.in_ready), 64'd1);
            end
        join
        drain32("drain32_stall");

        // Asynchronous reset mid-cycle with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            drive32(a, b, sub, model(32, 64'(a), 64'(b), sub, 1'b0));
            @(posedge clk);
            #1;
        end
        idle32();
        chk("pre_rst_valid", 64'(if32.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(if32.out_valid), 64'd0);
        chk("async_rst_sum", 64'(if32.out_sum), 64'd0);
        #3 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("rst_no_old", 64'(if32.out_valid), 64'd0);
        end
        latency32("lat32_post_rst");
        drain32("drain32_rst");

        // WIDTH=8, LPS=1 random traffic with random back-pressure and flushes.
        acc8 = 0;
        cyc  = 0;
        while (acc8 < 10000 && cyc < 60000) begin
            a   = 32'($urandom_range(0, 255));
            b   = 32'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SAT_EN
            sat = 1'($urandom_range(0, 1));
            if8.in_sat = sat;
`else
            sat = 1'b0;
`endif
            if8.in_valid  = ($urandom_range(0, 3) != 0);
            if8.in_a      = a[7:0];
            if8.in_b      = b[7:0];
            if8.in_sub    = sub;
            exp8          = model(8, 64'(a), 64'(b), sub, sat);
            if8.out_ready = ($urandom_range(0, 3) != 0);
            clr8          = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            if (if8.in_valid && if8.in_ready && !clr8)
                acc8++;
            @(posedge clk);
            #1;
            if (clr8)
                chk("clr_rdy8", 64'(if8.in_ready), 64'd1);
            cyc++;
        end
        chk("rnd8_ops_done", 64'(acc8 >= 10000), 64'd1);
        clr8 = 1'b0;
        idle8();
        drain8("drain8_rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
